// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sb_pkg
// Brief    : Shared-bus slave types and constants: bus field widths, the
//            responder state encoding and a beats-from-burst_size helper.
// Revision : 1.0 - initial release
// ============================================================================
package sb_pkg;

  localparam int SB_DATA_W  = 32;
  localparam int SB_BURST_W = 8;
  localparam int SB_BE_W    = 4;

  // Responder states; ST_ERR only exists when range checking is built in
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ISSUE  = 3'd1,
    ST_RD_STREAM = 3'd2,
    ST_RD_END    = 3'd3,
    ST_WR        = 3'd4
`ifdef SB_MEM_SLAVE_RANGE_ERR_EN
    ,
    ST_ERR       = 3'd5
`endif
  } sb_slave_state_t;

  // burst_size encodes beats-1; one extra bit holds the 256-beat case
  function automatic logic [SB_BURST_W:0] beats_from_burst(
    input logic [SB_BURST_W-1:0] burst_size
  );
    return {1'b0, burst_size} + {{SB_BURST_W{1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_mem_slave_ram.sv
`default_nettype none
// ============================================================================
// Module   : sb_mem_slave_ram
// Brief    : Synchronous single-port word RAM, one-cycle read latency,
//            per-byte write enables, read-before-write on a shared address.
// Revision : 1.0 - initial release
// ============================================================================
module sb_mem_slave_ram
  import sb_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 sys_clk,
  input  logic [AW-1:0]        i_addr,
  input  logic                 i_we,
  input  logic [SB_BE_W-1:0]   i_be,
  input  logic [SB_DATA_W-1:0] i_wdata,
  output logic [SB_DATA_W-1:0] o_rdata
);

  logic [SB_DATA_W-1:0] r_mem [DEPTH_WORDS];

  // Byte-lane writes and a registered read of the same address every cycle
  always_ff @(posedge sys_clk) begin
    if (i_we) begin
      for (int b = 0; b < SB_BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule
`default_nettype wire

// File: rtl/sb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : sb_mem_slave
// Brief    : Shared-bus memory responder. Decodes its address window, streams
//            read bursts with data_valid/end_transaction, absorbs write bursts
//            with byte enables. All outputs are zero when not responding, so
//            they can be OR-combined onto the shared bus.
//            Build option: SB_MEM_SLAVE_RANGE_ERR_EN - bursts that would run
//            past the window end get an error response instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sb_mem_slave
  import sb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic                  sb_clock_i,
  input  logic                  sb_reset_n_i,
  input  logic [SB_DATA_W-1:0]  sb_address_data_i,
  input  logic [SB_BE_W-1:0]    sb_byte_enables_i,
  input  logic [SB_BURST_W-1:0] sb_burst_size_i,
  input  logic                  sb_read_n_write_i,
  input  logic                  sb_begin_transaction_i,
  input  logic                  sb_end_transaction_i,
  input  logic                  sb_data_valid_i,
  output logic [SB_DATA_W-1:0]  sb_address_data_o,
  output logic                  sb_end_transaction_o,
  output logic                  sb_data_valid_o,
  output logic                  sb_busy_o,
  output logic                  sb_error_o
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] c_WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] c_WIN_HI = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  sb_slave_state_t       r_state;
  sb_slave_state_t       w_next_state;
  logic [AW-1:0]         r_index;
  logic [SB_BURST_W:0]   r_beats_left;
  logic                  w_hit;
  logic [AW-1:0]         w_index;
  logic                  w_ram_we;
  logic [SB_DATA_W-1:0]  w_rdata;
  logic                  w_err_pulse;

  // Window hit; BASE_ADDR is aligned to the window size, so the word index
  // is simply the address bits above the byte offset
  assign w_hit   = sb_begin_transaction_i &&
                   ({1'b0, sb_address_data_i} >= c_WIN_LO) &&
                   ({1'b0, sb_address_data_i} <  c_WIN_HI);
  assign w_index = sb_address_data_i[AW+1:2];

  // A write beat commits only while the burst still has beats outstanding
  assign w_ram_we = (r_state == ST_WR) && sb_data_valid_i && (r_beats_left != '0);

`ifdef SB_MEM_SLAVE_RANGE_ERR_EN
  logic        r_rnw;
  logic [1:0]  r_err_cnt;
  logic        r_err_end_seen;
  logic [32:0] w_span;
  logic        w_range_err;

  assign w_span      = 33'(w_index) + 33'(sb_burst_size_i);
  assign w_range_err = (w_span >= 33'(DEPTH_WORDS));
  // Error response lands on the second cycle after begin, like first read data
  assign w_err_pulse = (r_state == ST_ERR) && (r_err_cnt == 2'd1);
`else
  assign w_err_pulse = 1'b0;
`endif

  // State register
  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; begin outside IDLE is ignored
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
`ifdef SB_MEM_SLAVE_RANGE_ERR_EN
          if (w_range_err) w_next_state = ST_ERR;
          else
`endif
          if (sb_read_n_write_i) w_next_state = ST_RD_ISSUE;
          else                   w_next_state = ST_WR;
        end
      end
      ST_RD_ISSUE: begin
        w_next_state = sb_end_transaction_i ? ST_IDLE : ST_RD_STREAM;
      end
      ST_RD_STREAM: begin
        if (sb_end_transaction_i)                      w_next_state = ST_IDLE;
        else if (r_beats_left == (SB_BURST_W+1)'(1))   w_next_state = ST_RD_END;
      end
      ST_RD_END: begin
        w_next_state = ST_IDLE;
      end
      ST_WR: begin
        if (sb_end_transaction_i) w_next_state = ST_IDLE;
      end
`ifdef SB_MEM_SLAVE_RANGE_ERR_EN
      ST_ERR: begin
        // Reads finish with the pulse; writes also wait for the master's end
        if (r_err_cnt == 2'd1) begin
          if (r_rnw || r_err_end_seen || sb_end_transaction_i) w_next_state = ST_IDLE;
        end else if (r_err_cnt == 2'd2) begin
          if (sb_end_transaction_i) w_next_state = ST_IDLE;
        end
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: word index and remaining beats
  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i) begin
      r_index      <= '0;
      r_beats_left <= '0;
`ifdef SB_MEM_SLAVE_RANGE_ERR_EN
      r_rnw          <= 1'b0;
      r_err_cnt      <= 2'd0;
      r_err_end_seen <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_index      <= w_index;
            r_beats_left <= beats_from_burst(sb_burst_size_i);
`ifdef SB_MEM_SLAVE_RANGE_ERR_EN
            r_rnw          <= sb_read_n_write_i;
            r_err_cnt      <= 2'd0;
            r_err_end_seen <= 1'b0;
`endif
          end
        end
        ST_RD_ISSUE: begin
          r_index <= r_index + AW'(1);
        end
        ST_RD_STREAM: begin
          // Keep prefetching one word ahead of the beat being driven
          r_index <= r_index + AW'(1);
          if (r_beats_left != '0) r_beats_left <= r_beats_left - (SB_BURST_W+1)'(1);
        end
        ST_WR: begin
          if (w_ram_we) begin
            r_index      <= r_index + AW'(1);
            r_beats_left <= r_beats_left - (SB_BURST_W+1)'(1);
          end
        end
`ifdef SB_MEM_SLAVE_RANGE_ERR_EN
        ST_ERR: begin
          if (r_err_cnt != 2'd2)    r_err_cnt <= r_err_cnt + 2'd1;
          if (sb_end_transaction_i) r_err_end_seen <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  sb_mem_slave_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .sys_clk (sb_clock_i),
    .i_addr  (r_index),
    .i_we    (w_ram_we),
    .i_be    (sb_byte_enables_i),
    .i_wdata (sb_address_data_i),
    .o_rdata (w_rdata)
  );

  // Outputs decoded from state only, so async reset clears them at once
  always_comb begin
    sb_data_valid_o      = (r_state == ST_RD_STREAM);
    sb_address_data_o    = sb_data_valid_o ? w_rdata : '0;
    sb_end_transaction_o = (r_state == ST_RD_END) || w_err_pulse;
    sb_error_o           = w_err_pulse;
    sb_busy_o            = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_sb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_mem_slave
// Brief    : Directed self-checking bench for sb_mem_slave: single and burst
//            reads, byte-enable writes, decode misses, abort, async reset,
//            read-after-write and the window-end wrap / range error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sb_mem_slave;

  logic        sb_clock_i = 1'b0;
  logic        sb_reset_n_i;
  logic [31:0] sb_address_data_i;
  logic [3:0]  sb_byte_enables_i;
  logic [7:0]  sb_burst_size_i;
  logic        sb_read_n_write_i;
  logic        sb_begin_transaction_i;
  logic        sb_end_transaction_i;
  logic        sb_data_valid_i;
  logic [31:0] sb_address_data_o;
  logic        sb_end_transaction_o;
  logic        sb_data_valid_o;
  logic        sb_busy_o;
  logic        sb_error_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] wq [$];
  logic [31:0] eq [$];

  sb_mem_slave u_dut (
    .sb_clock_i             (sb_clock_i),
    .sb_reset_n_i           (sb_reset_n_i),
    .sb_address_data_i      (sb_address_data_i),
    .sb_byte_enables_i      (sb_byte_enables_i),
    .sb_burst_size_i        (sb_burst_size_i),
    .sb_read_n_write_i      (sb_read_n_write_i),
    .sb_begin_transaction_i (sb_begin_transaction_i),
    .sb_end_transaction_i   (sb_end_transaction_i),
    .sb_data_valid_i        (sb_data_valid_i),
    .sb_address_data_o      (sb_address_data_o),
    .sb_end_transaction_o   (sb_end_transaction_o),
    .sb_data_valid_o        (sb_data_valid_o),
    .sb_busy_o              (sb_busy_o),
    .sb_error_o             (sb_error_o)
  );

  always #5 sb_clock_i = ~sb_clock_i;

  // Flags packed as {busy, error, end, valid}
  function automatic logic [31:0] flags();
    return {28'd0, sb_busy_o, sb_error_o, sb_end_transaction_o, sb_data_valid_o};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    sb_address_data_i      = '0;
    sb_byte_enables_i      = '0;
    sb_burst_size_i        = '0;
    sb_read_n_write_i      = 1'b0;
    sb_begin_transaction_i = 1'b0;
    sb_end_transaction_i   = 1'b0;
    sb_data_valid_i        = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sb_clock_i);
    #1;
  endtask

  // Begin a write, then one beat per cycle from wq; end rides on the last beat
  task automatic sb_write(input logic [31:0] addr, input logic [7:0] burst,
                          input logic [3:0] be, input bit do_end);
    sb_address_data_i      = addr;
    sb_burst_size_i        = burst;
    sb_read_n_write_i      = 1'b0;
    sb_begin_transaction_i = 1'b1;
    @(posedge sb_clock_i); #1;
    sb_begin_transaction_i = 1'b0;
    for (int i = 0; i < wq.size(); i++) begin
      sb_data_valid_i      = 1'b1;
      sb_address_data_i    = wq[i];
      sb_byte_enables_i    = be;
      sb_end_transaction_i = do_end && (i == wq.size() - 1);
      @(posedge sb_clock_i); #1;
    end
    bus_idle();
  endtask

  // Begin a read and check every cycle against eq: data on cycles 2..N+1,
  // end pulse on N+2; abort_at drives end_i in that cycle; err_resp expects
  // an error+end pulse on cycle 2 and no data
  task automatic sb_read_check(input string tag, input logic [31:0] addr,
                               input logic [7:0] burst, input int abort_at,
                               input bit err_resp);
    int          n;
    logic        exp_v, exp_e, exp_er;
    logic [31:0] exp_d;
    n = int'(burst) + 1;
    sb_address_data_i      = addr;
    sb_burst_size_i        = burst;
    sb_read_n_write_i      = 1'b1;
    sb_begin_transaction_i = 1'b1;
    for (int i = 1; i <= n + 3; i++) begin
      @(posedge sb_clock_i); #1;
      sb_begin_transaction_i = 1'b0;
      sb_address_data_i      = '0;
      sb_end_transaction_i   = (abort_at != 0) && (i == abort_at);
      @(negedge sb_clock_i);
      if (err_resp) begin
        exp_v  = 1'b0;
        exp_e  = (i == 2);
        exp_er = (i == 2);
      end else begin
        exp_v  = (i >= 2) && (i < 2 + n) && ((abort_at == 0) || (i <= abort_at));
        exp_e  = (abort_at == 0) && (i == 2 + n);
        exp_er = 1'b0;
      end
      exp_d = exp_v ? eq[i-2] : 32'h0;
      check_eq($sformatf("%s_c%0d_flags", tag, i), flags(), {28'd0, 1'b0, exp_er, exp_e, exp_v});
      check_eq($sformatf("%s_c%0d_data", tag, i), sb_address_data_o, exp_d);
    end
    bus_idle();
    @(posedge sb_clock_i); #1;
  endtask

  initial begin
    bus_idle();
    sb_reset_n_i = 1'b0;
    wait_cycles(3);
    check_eq("reset_flags", flags(), 32'h0);
    check_eq("reset_data", sb_address_data_o, 32'h0);
    sb_reset_n_i = 1'b1;
    wait_cycles(2);

    // Single read
    wq = '{32'hDEAD_BEEF};
    sb_write(32'h0000_1000, 8'd0, 4'hF, 1'b1);
    wait_cycles(2);
    eq = '{32'hDEAD_BEEF};
    sb_read_check("single", 32'h0000_1000, 8'd0, 0, 1'b0);

    // Burst read
    wq = '{32'd1, 32'd2, 32'd3, 32'd4};
    sb_write(32'h0000_1000, 8'd3, 4'hF, 1'b1);
    wait_cycles(2);
    eq = '{32'd1, 32'd2, 32'd3, 32'd4};
    sb_read_check("burst", 32'h0000_1000, 8'd3, 0, 1'b0);

    // Byte-enable write over zero
    wq = '{32'h0};
    sb_write(32'h0000_1004, 8'd0, 4'hF, 1'b1);
    wait_cycles(1);
    wq = '{32'hAABB_CCDD};
    sb_write(32'h0000_1004, 8'd0, 4'b0101, 1'b1);
    wait_cycles(1);
    eq = '{32'h00BB_00DD};
    sb_read_check("byte_en", 32'h0000_1004, 8'd0, 0, 1'b0);

    // Decode miss below the window: silent for 20 cycles
    sb_address_data_i      = 32'h0000_0800;
    sb_read_n_write_i      = 1'b1;
    sb_begin_transaction_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge sb_clock_i); #1;
      bus_idle();
      @(negedge sb_clock_i);
      check_eq($sformatf("miss_c%0d", i), flags(), 32'h0);
    end
    wait_cycles(1);

    // Write just past the window end must not land on word 0
    wq = '{32'hFFFF_FFFF};
    sb_write(32'h0000_2000, 8'd0, 4'hF, 1'b1);
    wait_cycles(1);
    eq = '{32'd1};
    sb_read_check("miss_hi", 32'h0000_1000, 8'd0, 0, 1'b0);

    // Abort a 16-beat read while streaming, then a clean follow-up read
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(32'h100 + i);
    sb_write(32'h0000_1100, 8'd15, 4'hF, 1'b1);
    wait_cycles(1);
    eq = wq;
    sb_read_check("abort", 32'h0000_1100, 8'd15, 5, 1'b0);
    eq = '{32'h100};
    sb_read_check("post_abort", 32'h0000_1100, 8'd0, 0, 1'b0);

    // Read begun the cycle after a write's end sees the new word
    wq = '{32'h1234_5678};
    sb_write(32'h0000_1200, 8'd0, 4'hF, 1'b1);
    eq = '{32'h1234_5678};
    sb_read_check("raw", 32'h0000_1200, 8'd0, 0, 1'b0);

    // Async reset mid-read
    sb_address_data_i      = 32'h0000_1100;
    sb_burst_size_i        = 8'd15;
    sb_read_n_write_i      = 1'b1;
    sb_begin_transaction_i = 1'b1;
    @(posedge sb_clock_i); #1;
    bus_idle();
    repeat (3) @(posedge sb_clock_i);
    #1;
    check_eq("pre_rst_valid", flags(), 32'h1);
    #1;
    sb_reset_n_i = 1'b0;
    #1;
    check_eq("rst_rd_flags", flags(), 32'h0);
    check_eq("rst_rd_data", sb_address_data_o, 32'h0);
    @(negedge sb_clock_i);
    sb_reset_n_i = 1'b1;
    wait_cycles(1);

    // Async reset mid-write: committed beats survive
    wq = '{32'h55, 32'h66};
    sb_write(32'h0000_1300, 8'd3, 4'hF, 1'b0);
    #1;
    sb_reset_n_i = 1'b0;
    #1;
    check_eq("rst_wr_flags", flags(), 32'h0);
    @(negedge sb_clock_i);
    sb_reset_n_i = 1'b1;
    wait_cycles(1);
    eq = '{32'h55, 32'h66};
    sb_read_check("rst_wr", 32'h0000_1300, 8'd1, 0, 1'b0);

    // Burst starting two words before the window end
    wq = '{32'hA0, 32'hA1};
    sb_write(32'h0000_1FF8, 8'd1, 4'hF, 1'b1);
    wait_cycles(1);
`ifdef SB_MEM_SLAVE_RANGE_ERR_EN
    eq.delete();
    sb_read_check("range_err", 32'h0000_1FF8, 8'd3, 0, 1'b1);
`else
    eq = '{32'hA0, 32'hA1, 32'd1, 32'h00BB_00DD};
    sb_read_check("wrap", 32'h0000_1FF8, 8'd3, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sb_mem_slave.md
Name: sb_mem_slave

Overview:
- Shared-bus responder (slave) backed by an on-chip word RAM; it is the target end of the transactions the JTAG debug bridge initiates (burst reads/writes).
- Decodes its address window, returns read bursts with data_valid and end_transaction, and absorbs write bursts with byte enables.
- All outputs are OR-combined onto the shared bus, so every output is all-zero whenever the block is not actively responding.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte base address of the window; aligned to 4*DEPTH_WORDS.
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two.
- AW, $clog2(DEPTH_WORDS), word-index width (derived localparam).

Ports:
- sb_clock_i  in  1  bus clock; the block's only clock.
- sb_reset_n_i  in  1  reset, asynchronous, active-low.
- sb_address_data_i  in  32  address at begin; write data on data-valid beats.
- sb_byte_enables_i  in  4  write byte lanes; ignored for reads.
- sb_burst_size_i  in  8  beats minus 1 (0 means 1 beat, 255 means 256 beats).
- sb_read_n_write_i  in  1  1 = read, 0 = write; sampled at begin.
- sb_begin_transaction_i  in  1  one-cycle transaction start.
- sb_end_transaction_i  in  1  master end of write, or master abort.
- sb_data_valid_i  in  1  write beat valid.
- sb_address_data_o  out  32  read data; 0 when sb_data_valid_o = 0.
- sb_end_transaction_o  out  1  end of read, or end of error response.
- sb_data_valid_o  out  1  read beat valid.
- sb_busy_o  out  1  always 0; reserved.
- sb_error_o  out  1  error response.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters 0; RAM contents not cleared.
- Decode: a hit is begin = 1 and BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS. On a miss, do nothing and drive all outputs 0.
- Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
- States: IDLE, RD_ISSUE, RD_STREAM, RD_END, WR, ERR.
- IDLE:
  - Hit with begin sampled at edge T: latch index, beats_left = burst_size + 1, and rnw.
  - Read goes to RD_ISSUE; write goes to WR.
- RD_ISSUE (cycle T+1): issue RAM read of the first word, then go to RD_STREAM.
- RD_STREAM:
  - From cycle T+2, drive sb_data_valid_o = 1 with consecutive words on back-to-back cycles, with no gaps.
  - The index increments by 1 per beat and wraps modulo DEPTH_WORDS.
  - After the last beat, go to RD_END.
- RD_END: sb_end_transaction_o = 1 for exactly one cycle, directly after the last data beat; then IDLE.
- WR:
  - Each cycle with sb_data_valid_i = 1 and beats_left > 0: write the word with its byte enables, increment the index (wrapping), and decrement beats_left.
  - Valid beats arriving when beats_left = 0 are ignored.
  - sb_end_transaction_i = 1 returns to IDLE next cycle. If a valid beat arrives in the same cycle as end, the beat is written first.
- Abort: sb_end_transaction_i = 1 during RD_ISSUE or RD_STREAM stops output the next cycle (outputs 0, no RD_END pulse) and returns to IDLE.
- sb_begin_transaction_i while not IDLE is ignored, with no response.
- Read-after-write: a read begun the cycle after a write's end returns the new data.
- Reset mid-transaction: outputs drop to 0 immediately (asynchronous); in-flight writes already committed remain.

Optional Feature:
- Macro SB_MEM_SLAVE_RANGE_ERR_EN.
- Defined:
  - At begin, if index + burst_size >= DEPTH_WORDS (burst would cross the window end), enter ERR.
  - ERR, at cycle T+2: sb_error_o = 1 and sb_end_transaction_o = 1 for one cycle, with no data beats. No RAM writes; write beats are ignored until the master's sb_end_transaction_i, then IDLE.
- Not defined: no ERR state; sb_error_o tied 0; bursts wrap modulo DEPTH_WORDS.

Decomposition:
- Package sb_pkg: SB_DATA_W = 32, SB_BURST_W = 8, SB_BE_W = 4, the state enum type sb_slave_state_t, and a beats-from-burst_size helper function.
- One sub-module, sb_mem_slave_ram: synchronous single-port RAM with one-cycle read latency and a per-byte write enable.

Test Plan:
- Single read: write 32'hDEAD_BEEF at 0x1000, then read 0x1000 with burst_size 0. Expect data_valid at T+2 with DEADBEEF, end_transaction at T+3, and outputs 0 otherwise.
- Burst read: preload 0x1000..0x100C with 1..4, read burst_size 3. Expect 4 consecutive valid beats 1, 2, 3, 4, then a one-cycle end.
- Byte-enable write: write 32'hAABBCCDD at 0x1004 with BE 4'b0101 over 32'h0, then read it back. Expect 32'h00BB00DD.
- Decode miss: begin at 0x0000_0800. Expect no data_valid, end or error for 20 cycles.
- Abort and reset: assert end_transaction_i in the middle of a 16-beat read. Expect valid drops the next cycle with no end pulse. Assert reset mid-write and expect all outputs 0 immediately.
- Range error (with macro): read at BASE + 4*(DEPTH-2) with burst_size 3. Expect error + end at T+2 and no data. Without the macro, expect 4 beats wrapping to word 0.
